// File: rtl/rpn_pkg.sv
// ============================================================================
//  Module   : rpn_pkg
//  Purpose  : Shared token kinds, operator codes, ASCII constants and the
//             character class enum for the RPN tokenizer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rpn_pkg;

    localparam logic [1:0] TOK_NUM = 2'd0;
    localparam logic [1:0] TOK_OP  = 2'd1;
    localparam logic [1:0] TOK_EOL = 2'd2;
    localparam logic [1:0] TOK_ERR = 2'd3;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_PLUS  = 8'h2B;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_STAR  = 8'h2A;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TAB   = 8'h09;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

    typedef enum logic [2:0] {
        CLS_DIGIT   = 3'd0,
        CLS_OP      = 3'd1,
        CLS_SPACE   = 3'd2,
        CLS_EOL     = 3'd3,
        CLS_INVALID = 3'd4
    } char_class_t;

    // Token kind produced by a non-digit, non-space delimiter.
    function automatic logic [1:0] delim_kind(input char_class_t cls);
        case (cls)
            CLS_OP:  delim_kind = TOK_OP;
            CLS_EOL: delim_kind = TOK_EOL;
            default: delim_kind = TOK_ERR;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ascii_classify.sv
// ============================================================================
//  Module   : ascii_classify
//  Purpose  : Combinational byte classifier: class, digit value, operator code.
//             RPN_TOK_CRLF_EN treats carriage return as whitespace.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascii_classify
    import rpn_pkg::*;
(
    input  logic [7:0]  in_byte,
    output char_class_t cls,
    output logic [3:0]  digit,
    output logic [3:0]  op
);

    always_comb begin
        cls   = CLS_INVALID;
        digit = 4'd0;
        op    = 4'd0;
        if ((in_byte >= ASCII_0) && (in_byte <= ASCII_9)) begin
            cls   = CLS_DIGIT;
            digit = in_byte[3:0];
        end else begin
            case (in_byte)
                ASCII_PLUS:  begin cls = CLS_OP; op = OP_ADD; end
                ASCII_MINUS: begin cls = CLS_OP; op = OP_SUB; end
                ASCII_STAR:  begin cls = CLS_OP; op = OP_MUL; end
                ASCII_SLASH: begin cls = CLS_OP; op = OP_DIV; end
                ASCII_SPACE: cls = CLS_SPACE;
                ASCII_TAB:   cls = CLS_SPACE;
                ASCII_LF:    cls = CLS_EOL;
`ifdef RPN_TOK_CRLF_EN
                ASCII_CR:    cls = CLS_SPACE;
`endif
                default:     cls = CLS_INVALID;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/rpn_tokenizer.sv
// ============================================================================
//  Module   : rpn_tokenizer
//  Purpose  : Byte-stream tokenizer emitting NUM/OP/EOL/ERR tokens over
//             valid/ready. Optional macro RPN_TOK_CRLF_EN (CR as space).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rpn_tokenizer
    import rpn_pkg::*;
#(
    parameter int NUM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [7:0]           in_byte,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_kind,
    output logic [NUM_WIDTH-1:0] out_value,
    output logic [3:0]           out_op,
    output logic                 out_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_PEND  = 2'd2
    } state_t;

    state_t                r_state, w_state_next;
    logic [NUM_WIDTH-1:0]  r_acc, w_acc_next;
    logic                  r_ovf, w_ovf_next;
    logic [1:0]            r_pend_kind, w_pend_kind_next;
    logic [3:0]            r_pend_op, w_pend_op_next;
    logic                  r_out_valid, w_out_valid_next;
    logic [1:0]            r_out_kind, w_out_kind_next;
    logic [NUM_WIDTH-1:0]  r_out_value, w_out_value_next;
    logic [3:0]            r_out_op, w_out_op_next;
    logic                  r_out_ovf, w_out_ovf_next;

    char_class_t           w_cls;
    logic [3:0]            w_digit;
    logic [3:0]            w_op;
    logic                  w_accept;
    logic                  w_out_fire;
    logic [NUM_WIDTH+3:0]  w_full;

    ascii_classify u_classify (
        .in_byte (in_byte),
        .cls     (w_cls),
        .digit   (w_digit),
        .op      (w_op)
    );

    assign in_ready   = !rst && (r_state != ST_PEND) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;

    // acc*10 + digit as (acc<<3)+(acc<<1)+digit; the top 4 bits flag overflow.
    assign w_full = ({4'd0, r_acc} << 3) + ({4'd0, r_acc} << 1)
                  + {{NUM_WIDTH{1'b0}}, w_digit};

    assign out_valid = r_out_valid;
    assign out_kind  = r_out_kind;
    assign out_value = r_out_value;
    assign out_op    = r_out_op;
    assign out_ovf   = r_out_ovf;

    always_comb begin
        w_state_next     = r_state;
        w_acc_next       = r_acc;
        w_ovf_next       = r_ovf;
        w_pend_kind_next = r_pend_kind;
        w_pend_op_next   = r_pend_op;
        w_out_valid_next = r_out_valid && !out_ready;
        w_out_kind_next  = r_out_kind;
        w_out_value_next = r_out_value;
        w_out_op_next    = r_out_op;
        w_out_ovf_next   = r_out_ovf;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_cls == CLS_DIGIT) begin
                        w_acc_next   = {{(NUM_WIDTH-4){1'b0}}, w_digit};
                        w_ovf_next   = 1'b0;
                        w_state_next = ST_ACCUM;
                    end else if (w_cls != CLS_SPACE) begin
                        w_out_valid_next = 1'b1;
                        w_out_kind_next  = delim_kind(w_cls);
                        w_out_value_next = '0;
                        w_out_op_next    = (w_cls == CLS_OP) ? w_op : 4'd0;
                        w_out_ovf_next   = 1'b0;
                    end
                end
            end
            ST_ACCUM: begin
                if (w_accept) begin
                    if (w_cls == CLS_DIGIT) begin
                        w_acc_next = w_full[NUM_WIDTH-1:0];
                        w_ovf_next = r_ovf || (w_full[NUM_WIDTH+3:NUM_WIDTH] != 4'd0);
                    end else begin
                        w_out_valid_next = 1'b1;
                        w_out_kind_next  = TOK_NUM;
                        w_out_value_next = r_acc;
                        w_out_op_next    = 4'd0;
                        w_out_ovf_next   = r_ovf;
                        if (w_cls == CLS_SPACE) begin
                            w_state_next = ST_IDLE;
                        end else begin
                            w_pend_kind_next = delim_kind(w_cls);
                            w_pend_op_next   = (w_cls == CLS_OP) ? w_op : 4'd0;
                            w_state_next     = ST_PEND;
                        end
                    end
                end
            end
            ST_PEND: begin
                // Delimiter token follows the NUM with no idle cycle between.
                if (w_out_fire) begin
                    w_out_valid_next = 1'b1;
                    w_out_kind_next  = r_pend_kind;
                    w_out_value_next = '0;
                    w_out_op_next    = r_pend_op;
                    w_out_ovf_next   = 1'b0;
                    w_state_next     = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_pend_kind <= TOK_NUM;
            r_pend_op   <= 4'd0;
            r_out_valid <= 1'b0;
            r_out_kind  <= TOK_NUM;
            r_out_value <= '0;
            r_out_op    <= 4'd0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_ovf       <= w_ovf_next;
            r_pend_kind <= w_pend_kind_next;
            r_pend_op   <= w_pend_op_next;
            r_out_valid <= w_out_valid_next;
            r_out_kind  <= w_out_kind_next;
            r_out_value <= w_out_value_next;
            r_out_op    <= w_out_op_next;
            r_out_ovf   <= w_out_ovf_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rpn_tokenizer.sv
// ============================================================================
//  Module   : tb_rpn_tokenizer
//  Purpose  : Directed self-checking bench for rpn_tokenizer (NUM_WIDTH=16).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rpn_tokenizer;

    localparam logic [1:0] K_NUM = 2'd0;
    localparam logic [1:0] K_OP  = 2'd1;
    localparam logic [1:0] K_EOL = 2'd2;
    localparam logic [1:0] K_ERR = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] value;
        logic [3:0]  op;
        logic        ovf;
    } tok_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_kind;
    logic [15:0] out_value;
    logic [3:0]  out_op;
    logic        out_ovf;

    int   n_checks = 0;
    int   n_fail   = 0;
    tok_t got_q[$];
    tok_t exp_q[$];
    logic took;

    always #5 clk = ~clk;

    rpn_tokenizer #(.NUM_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_kind  (out_kind),
        .out_value (out_value),
        .out_op    (out_op),
        .out_ovf   (out_ovf)
    );

    function automatic tok_t mk(input logic [1:0] k, input logic [15:0] v,
                                input logic [3:0] o, input logic f);
        return {k, v, o, f};
    endfunction

    // Drive one cycle's inputs at the falling edge and log the handshakes
    // that the next rising edge will perform.
    task automatic cycle_io(input logic v, input logic [7:0] b, input logic r,
                            output logic tk);
        @(negedge clk);
        in_valid  = v;
        in_byte   = b;
        out_ready = r;
        #1;
        tk = in_valid && in_ready;
        if (out_valid && out_ready)
            got_q.push_back({out_kind, out_value, out_op, out_ovf});
    endtask

    task automatic send(input string s, input bit rnd);
        int       idx = 0;
        int       drain = 0;
        int       cyc = 0;
        logic     v;
        logic     r;
        logic     tk;
        logic [7:0] b;
        while (!((idx == s.len()) && (drain >= 8)) && (cyc < 2000)) begin
            v = (idx < s.len()) && (!rnd || ($urandom_range(0, 2) != 0));
            r = (idx == s.len()) || !rnd || ($urandom_range(0, 1) == 1);
            b = (idx < s.len()) ? s[idx] : 8'h00;
            cycle_io(v, b, r, tk);
            if (tk) idx++;
            if (idx == s.len()) drain++;
            cyc++;
        end
        n_checks++;
        assert (idx === s.len()) else begin
            n_fail++;
            $error("FAIL send_timeout: consumed %0d bytes, required %0d", idx, s.len());
        end
    endtask

    task automatic check_tokens(input string tag);
        n_checks++;
        assert (got_q.size() === exp_q.size()) else begin
            n_fail++;
            $error("FAIL %s count: observed %0d tokens, expected %0d", tag, got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                n_checks++;
                assert (got_q[i] === exp_q[i]) else begin
                    n_fail++;
                    $error("FAIL %s tok%0d: observed kind=%0d value=%0d op=%0d ovf=%0d, expected kind=%0d value=%0d op=%0d ovf=%0d",
                           tag, i, got_q[i].kind, got_q[i].value, got_q[i].op, got_q[i].ovf,
                           exp_q[i].kind, exp_q[i].value, exp_q[i].op, exp_q[i].ovf);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_byte   = "5";
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk_vec("reset_state",
                {8'd0, out_valid, in_ready, out_kind, out_value, out_op, out_ovf},
                32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;

        send("12 3+\n", 1'b0);
        exp_q.push_back(mk(K_NUM, 16'd12, 4'd0, 1'b0));
        exp_q.push_back(mk(K_NUM, 16'd3,  4'd0, 1'b0));
        exp_q.push_back(mk(K_OP,  16'd0,  4'd0, 1'b0));
        exp_q.push_back(mk(K_EOL, 16'd0,  4'd0, 1'b0));
        check_tokens("basic");

        send("+-*/8\t9\n", 1'b0);
        exp_q.push_back(mk(K_OP,  16'd0, 4'd0, 1'b0));
        exp_q.push_back(mk(K_OP,  16'd0, 4'd1, 1'b0));
        exp_q.push_back(mk(K_OP,  16'd0, 4'd2, 1'b0));
        exp_q.push_back(mk(K_OP,  16'd0, 4'd3, 1'b0));
        exp_q.push_back(mk(K_NUM, 16'd8, 4'd0, 1'b0));
        exp_q.push_back(mk(K_NUM, 16'd9, 4'd0, 1'b0));
        exp_q.push_back(mk(K_EOL, 16'd0, 4'd0, 1'b0));
        check_tokens("ops_tab");

        // 65536 -> 0, 70000 -> 4464, 100000 -> 34464, all overflowed.
        send("65536 70000 100000\n", 1'b0);
        exp_q.push_back(mk(K_NUM, 16'd0,     4'd0, 1'b1));
        exp_q.push_back(mk(K_NUM, 16'd4464,  4'd0, 1'b1));
        exp_q.push_back(mk(K_NUM, 16'd34464, 4'd0, 1'b1));
        exp_q.push_back(mk(K_EOL, 16'd0,     4'd0, 1'b0));
        check_tokens("overflow");

        // NUM held under backpressure, then OP follows without a bubble.
        cycle_io(1'b1, "7", 1'b1, took);
        cycle_io(1'b1, "*", 1'b1, took);
        for (int i = 0; i < 5; i++) begin
            cycle_io(1'b0, 8'h00, 1'b0, took);
            chk_vec("stall_hold",
                    {8'd0, out_valid, in_ready, out_kind, out_value, out_op, out_ovf},
                    {8'd0, 1'b1, 1'b0, K_NUM, 16'd7, 4'd0, 1'b0});
        end
        cycle_io(1'b0, 8'h00, 1'b1, took);
        chk_vec("stall_release",
                {8'd0, out_valid, in_ready, out_kind, out_value, out_op, out_ovf},
                {8'd0, 1'b1, 1'b0, K_NUM, 16'd7, 4'd0, 1'b0});
        cycle_io(1'b0, 8'h00, 1'b1, took);
        chk_vec("stall_op_next",
                {8'd0, out_valid, in_ready, out_kind, out_value, out_op, out_ovf},
                {8'd0, 1'b1, 1'b1, K_OP, 16'd0, 4'd2, 1'b0});
        cycle_io(1'b0, 8'h00, 1'b1, took);
        chk_vec("stall_drained", {31'd0, out_valid}, 32'd0);
        got_q.delete();

        send("4a\n", 1'b0);
        exp_q.push_back(mk(K_NUM, 16'd4, 4'd0, 1'b0));
        exp_q.push_back(mk(K_ERR, 16'd0, 4'd0, 1'b0));
        exp_q.push_back(mk(K_EOL, 16'd0, 4'd0, 1'b0));
        check_tokens("invalid");

        send("5\015\n", 1'b0);
        exp_q.push_back(mk(K_NUM, 16'd5, 4'd0, 1'b0));
`ifndef RPN_TOK_CRLF_EN
        exp_q.push_back(mk(K_ERR, 16'd0, 4'd0, 1'b0));
`endif
        exp_q.push_back(mk(K_EOL, 16'd0, 4'd0, 1'b0));
        check_tokens("crlf");

        // Asynchronous reset in the middle of a number.
        send("98", 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_vec("async_reset", {30'd0, out_valid, in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send("1 ", 1'b0);
        exp_q.push_back(mk(K_NUM, 16'd1, 4'd0, 1'b0));
        check_tokens("after_reset");

        send("65535 1/2-\n", 1'b1);
        exp_q.push_back(mk(K_NUM, 16'd65535, 4'd0, 1'b0));
        exp_q.push_back(mk(K_NUM, 16'd1,     4'd0, 1'b0));
        exp_q.push_back(mk(K_OP,  16'd0,     4'd3, 1'b0));
        exp_q.push_back(mk(K_NUM, 16'd2,     4'd0, 1'b0));
        exp_q.push_back(mk(K_OP,  16'd0,     4'd1, 1'b0));
        exp_q.push_back(mk(K_EOL, 16'd0,     4'd0, 1'b0));
        check_tokens("random_bp");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
